// File: rtl/pulsos_pkg.sv
// pulsos_pkg: shared state encoding and default widths for the pulse generator and its detector bench.
// Contents: ST_* state codes (2 bits), estado_t FSM state type, PULSOS_* default field widths.
package pulsos_pkg;
  localparam int PULSOS_WIDTH_BITS = 8;
  localparam int PULSOS_COUNT_BITS = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HIGH = ST_HIGH,
    S_LOW  = ST_LOW,
    S_DONE = ST_DONE
  } estado_t;
endpackage

// File: rtl/generador_pulsos_if.sv
// generador_pulsos_if: command/status bundle of the pulse-train generator.
// master: drives Start, Abort, Pulse_count, High_cycles, Low_cycles; sees Pulse, Busy, Done, Sent_count.
// slave : the generator side, with the directions reversed.
interface generador_pulsos_if #(
  parameter int WIDTH_BITS = 8,
  parameter int COUNT_BITS = 8
) ();
  logic                  Start;
  logic                  Abort;
  logic [COUNT_BITS-1:0] Pulse_count;
  logic [WIDTH_BITS-1:0] High_cycles;
  logic [WIDTH_BITS-1:0] Low_cycles;
  logic                  Pulse;
  logic                  Busy;
  logic                  Done;
  logic [COUNT_BITS-1:0] Sent_count;
  modport master (
    output Start, Abort, Pulse_count, High_cycles, Low_cycles,
    input  Pulse, Busy, Done, Sent_count
  );
  modport slave (
    input  Start, Abort, Pulse_count, High_cycles, Low_cycles,
    output Pulse, Busy, Done, Sent_count
  );
endinterface

// File: rtl/contador_fase.sv
// contador_fase: loadable down-counter timing one HIGH or LOW phase of a pulse.
// Ports: CLK clock; Reset async active-low; i_load loads i_value; o_zero flags the last cycle of the phase.
module contador_fase #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  logic [W-1:0] w_start;
  // A phase of V cycles starts at V-1 so zero marks its final cycle; V=0 behaves as V=1.
  assign w_start = (i_value == '0) ? '0 : i_value - 1'b1;
  assign o_zero  = (r_cnt == '0);
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) r_cnt <= '0;
    else        r_cnt <= i_load ? w_start : o_zero ? r_cnt : r_cnt - 1'b1;
endmodule

// File: rtl/generador_pulsos.sv
// generador_pulsos: emits a burst of N pulses, each H cycles high and L cycles low, on command.
// Ports: CLK clock; Reset async active-low; bus (slave) carries Start/Abort/config in and Pulse/Busy/Done/Sent_count out.
module generador_pulsos
  import pulsos_pkg::*;
#(
  parameter int WIDTH_BITS = PULSOS_WIDTH_BITS,
  parameter int COUNT_BITS = PULSOS_COUNT_BITS
) (
  input logic                CLK,
  input logic                Reset,
  generador_pulsos_if.slave  bus
);
  estado_t               r_state;
  logic                  r_pulse;
  logic                  r_busy;
  logic                  r_done;
  logic [COUNT_BITS-1:0] r_sent;
  logic [COUNT_BITS-1:0] r_count;
  logic [WIDTH_BITS-1:0] r_high;
  logic [WIDTH_BITS-1:0] r_low;
  logic                  w_zero;
  logic                  w_load;
  logic [WIDTH_BITS-1:0] w_value;
  // One counter serves both phases: reload on every phase change, from the live
  // config on Start (shadows not yet written) and from the shadows afterwards.
  assign w_load = ((r_state == S_IDLE) && bus.Start && (bus.Pulse_count != '0)) ||
                  ((r_state == S_HIGH) && w_zero) ||
                  ((r_state == S_LOW) && w_zero && (r_sent != r_count));
  assign w_value = (r_state == S_IDLE) ? bus.High_cycles :
                   (r_state == S_HIGH) ? r_low : r_high;
  contador_fase #(.W(WIDTH_BITS)) u_fase (
    .CLK     (CLK),
    .Reset   (Reset),
    .i_load  (w_load),
    .i_value (w_value),
    .o_zero  (w_zero)
  );
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      r_state <= S_IDLE;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sent  <= '0;
      r_count <= '0;
      r_high  <= '0;
      r_low   <= '0;
    end else begin
      r_done <= 1'b0;
      // Abort wins over everything, including a Start seen in IDLE; Sent_count is kept.
      if (bus.Abort) begin
        r_state <= S_IDLE;
        r_pulse <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE:
            if (bus.Start) begin
              r_count <= bus.Pulse_count;
              r_high  <= bus.High_cycles;
              r_low   <= bus.Low_cycles;
              r_sent  <= '0;
              r_busy  <= 1'b1;
              if (bus.Pulse_count == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_HIGH;
                r_pulse <= 1'b1;
              end
            end
          S_HIGH:
            if (w_zero) begin
              r_state <= S_LOW;
              r_pulse <= 1'b0;
              r_sent  <= r_sent + 1'b1;
            end
          S_LOW:
            if (w_zero) begin
              if (r_sent == r_count) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_HIGH;
                r_pulse <= 1'b1;
              end
            end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  assign bus.Pulse      = r_pulse;
  assign bus.Busy       = r_busy;
  assign bus.Done       = r_done;
  assign bus.Sent_count = r_sent;
endmodule

// File: tb/tb_generador_pulsos.sv
// tb_generador_pulsos: randomized and directed bursts checked cycle by cycle against an arithmetic model.
module tb_generador_pulsos;
  logic CLK = 1'b0;
  logic Reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   sent_last = 0;
  always #5 CLK = ~CLK;
  generador_pulsos_if #(.WIDTH_BITS(8), .COUNT_BITS(8)) bus ();
  generador_pulsos dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic chk_outs(input string tag, input logic p, input logic b, input logic d, input int s);
    chk({tag, " pulse"}, 32'(bus.Pulse), 32'(p));
    chk({tag, " busy"},  32'(bus.Busy),  32'(b));
    chk({tag, " done"},  32'(bus.Done),  32'(d));
    chk({tag, " sent"},  32'(bus.Sent_count), 32'(s));
  endtask
  // Outputs t cycles after the Start capture edge: pulses of period He+Le, then one DONE cycle.
  function automatic void model(input int n, input int h, input int l, input int t,
                                output logic p, output logic b, output logic d, output int s);
    int he  = (h == 0) ? 1 : h;
    int le  = (l == 0) ? 1 : l;
    int per = he + le;
    int dn  = n * per;
    if (t < dn) begin
      p = (t % per) < he;
      s = t / per + (((t % per) >= he) ? 1 : 0);
      b = 1'b1;
      d = 1'b0;
    end else begin
      p = 1'b0;
      b = (t == dn);
      d = (t == dn);
      s = n;
    end
  endfunction
  task automatic drive_cfg(input int n, input int h, input int l);
    bus.Start       = 1'b1;
    bus.Abort       = 1'b0;
    bus.Pulse_count = 8'(n);
    bus.High_cycles = 8'(h);
    bus.Low_cycles  = 8'(l);
  endtask
  // Checks every cycle of a burst whose Start was driven before the next edge;
  // ab>0 aborts at capture edge ab; hold keeps Start high throughout.
  task automatic run_burst(input int n, input int h, input int l, input int ab, input bit hold);
    logic p, b, d;
    int   s;
    int   he = (h == 0) ? 1 : h;
    int   le = (l == 0) ? 1 : l;
    int   last = n * (he + le) + 1;
    for (int t = 0; t <= last; t++) begin
      @(negedge CLK);
      if (ab > 0 && t >= ab) begin
        model(n, h, l, ab - 1, p, b, d, s);
        p = 1'b0;
        b = 1'b0;
        d = 1'b0;
      end else model(n, h, l, t, p, b, d, s);
      chk_outs($sformatf("n%0d h%0d l%0d t%0d", n, h, l, t), p, b, d, s);
      sent_last = s;
      if (t == 0) begin
        if (!hold) bus.Start = 1'b0;
        bus.Pulse_count = 8'($urandom);
        bus.High_cycles = 8'($urandom);
        bus.Low_cycles  = 8'($urandom);
      end
      bus.Abort = (ab > 0 && t == ab - 1);
      if (ab > 0 && t == ab) break;
    end
  endtask
  initial begin
    int n, h, l, ab, r, he, le;
    bit hold;
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    bus.Pulse_count = '0;
    bus.High_cycles = '0;
    bus.Low_cycles  = '0;
    repeat (2) @(negedge CLK);
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 0);
    Reset = 1'b1;
    @(negedge CLK);
    drive_cfg(3, 4, 2);
    run_burst(3, 4, 2, 0, 0);
    drive_cfg(0, 5, 5);
    run_burst(0, 5, 5, 0, 0);
    drive_cfg(2, 0, 0);
    run_burst(2, 0, 0, 0, 0);
    drive_cfg(10, 8, 2);
    run_burst(10, 8, 2, 33, 0);
    drive_cfg(5, 4, 2);
    run_burst(5, 4, 2, 0, 1);
    drive_cfg(2, 1, 3);
    run_burst(2, 1, 3, 0, 0);
    bus.Start = 1'b1;
    bus.Abort = 1'b1;
    bus.Pulse_count = 8'd4;
    @(negedge CLK);
    chk_outs("abort_idle", 1'b0, 1'b0, 1'b0, sent_last);
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    for (int i = 0; i < 25; i++) begin
      n = $urandom_range(0, 10);
      h = $urandom_range(0, 8);
      l = $urandom_range(0, 8);
      he = (h == 0) ? 1 : h;
      le = (l == 0) ? 1 : l;
      ab = 0;
      hold = 1'b0;
      r = $urandom_range(0, 3);
      if (r == 0 && n > 0) ab = $urandom_range(1, n * (he + le));
      else if (r == 1) hold = 1'b1;
      drive_cfg(n, h, l);
      run_burst(n, h, l, ab, hold);
    end
    bus.Start = 1'b0;
    @(negedge CLK);
    drive_cfg(5, 4, 2);
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (2) @(negedge CLK);
    chk("mid_burst pulse", 32'(bus.Pulse), 32'd1);
    #2 Reset = 1'b0;
    #1 chk_outs("async_reset", 1'b0, 1'b0, 1'b0, 0);
    repeat (7) @(negedge CLK);
    Reset = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk_outs("after_reset", 1'b0, 1'b0, 1'b0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/generador_pulsos.md
# generador_pulsos

Programmable pulse-train generator for the pulse-counter design: on command it emits N pulses on `Pulse`, each high for a configured number of clock cycles and separated by a configured low gap. It is the stimulus side of the high-level pulse detector, used on-board and in benches to produce countable, width-qualified pulses. One clock domain; fully registered outputs.

## Interface

- `WIDTH_BITS`, 8: width of the high/low duration fields.
- `COUNT_BITS`, 8: width of the pulse-count field and `Sent_count`.

- `CLK`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request a burst; sampled only in IDLE.
- `Abort`  in  1  terminate the burst in progress.
- `Pulse_count`  in  COUNT_BITS  number of pulses in the burst.
- `High_cycles`  in  WIDTH_BITS  high duration in cycles.
- `Low_cycles`  in  WIDTH_BITS  low gap in cycles.
- `Pulse`  out  1  generated pulse train.
- `Busy`  out  1  burst in progress (HIGH, LOW or DONE).
- `Done`  out  1  one-cycle strobe at normal burst completion.
- `Sent_count`  out  COUNT_BITS  pulses completed in the current/last burst.

## Operation

- Reset (`Reset`=0, asynchronous): state IDLE; `Pulse`=0, `Busy`=0, `Done`=0, `Sent_count`=0; internal counters 0.
- States: IDLE, HIGH, LOW, DONE.
- IDLE: `Start`=1 latches `Pulse_count`, `High_cycles`, `Low_cycles` into shadow registers and clears `Sent_count`.
  - If latched count = 0: go to DONE, no pulse.
  - Otherwise: go to HIGH.
- Inputs are ignored outside IDLE, except `Abort`. Changing the config mid-burst has no effect.
- Zero durations: `High_cycles`=0 is treated as 1, and `Low_cycles`=0 is treated as 1. This guarantees every pulse has a rising and a falling edge.
- HIGH: `Pulse`=1 for H cycles. On exit, `Sent_count` increments and the state goes to LOW.
- LOW: `Pulse`=0 for L cycles.
  - If `Sent_count` equals the latched count: go to DONE.
  - Otherwise: go to HIGH.
- DONE: `Done`=1 and `Busy`=1 for exactly one cycle, then IDLE.
- `Abort`=1 in HIGH/LOW/DONE: go to IDLE at the next edge.
  - `Pulse`=0 and `Busy`=0 from that edge.
  - `Done` is not asserted.
  - `Sent_count` holds its value.
  - `Abort` has priority over all other transitions. `Abort` in IDLE has priority over `Start` (no burst starts).
- `Start` held high in DONE is ignored. A `Start` still high in the following IDLE cycle starts a new burst. Back-to-back bursts therefore have a 1-cycle IDLE gap.
- `Sent_count` holds after completion until the next accepted `Start`. It saturates by construction because it is bounded by the latched count.

## Timing

- `Start` sampled at edge k (IDLE) → `Pulse` rises at edge k+1, and `Busy` rises at edge k+1.
- Each pulse is high for exactly H cycles, then low for exactly L cycles.
- Burst length in cycles = N·(H+L), then 1 DONE cycle. With N=0, DONE occurs at edge k+1.
- `Done` is high during the cycle after the last LOW cycle. `Busy` falls at the following edge.
- `Sent_count` updates at the same edge where `Pulse` falls.
- All outputs come directly from flops; there is no combinational input-to-output path.

## Structure

- Shared package `pulsos_pkg`:
  - state encoding localparams (IDLE/HIGH/LOW/DONE, 2 bits);
  - default width constants shared with the detector bench.
- Sub-module `contador_fase`: loadable down-counter with `load`, `value` and `zero` outputs, reused for both the HIGH and LOW phases.
- The top holds the FSM, shadow registers and `Sent_count`.

## Test plan

- Reset low mid-burst (N=5, H=4, L=2, released after 7 cycles) → outputs 0 immediately (asynchronously); IDLE after release; no `Done`.
- N=3, H=4, L=2 → three 4-cycle-high pulses with 2-cycle gaps; `Done` 19 cycles after the `Start` edge; `Sent_count`=3; downstream 4-cycle-high detector counts 3.
- N=0 → no pulse; `Done` one cycle after `Start`; `Sent_count`=0.
- H=0, L=0, N=2 → pulses 1 high/1 low (pattern 1,0,1,0); `Done` at cycle 5.
- N=10, H=8, L=2, `Abort` during the 4th pulse → `Pulse` low next edge; `Busy`=0; no `Done`; `Sent_count`=3.
- Config changed mid-burst and `Start` held high through DONE → burst uses the originally latched values; new burst starts after the 1-cycle IDLE gap with the new values.
